// File: rtl/wash_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : wash_pkg
// Brief  : Encodings, default durations and sequencing helpers for the washer.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package wash_pkg;

    localparam int unsigned TIME_W        = 7;
    localparam int unsigned DEF_T_WASH    = 9;
    localparam int unsigned DEF_T_RINSE   = 6;
    localparam int unsigned DEF_T_SPIN    = 3;
    localparam int unsigned DEF_ORDER_MAX = 24;

    typedef logic [TIME_W-1:0] ticks_t;

    typedef enum logic [2:0] {
        MODEL_WRS = 3'b000,
        MODEL_W   = 3'b001,
        MODEL_WR  = 3'b010,
        MODEL_R   = 3'b011,
        MODEL_RS  = 3'b100,
        MODEL_S   = 3'b101
    } model_e;

    typedef enum logic [1:0] {
        PH_WASH  = 2'b00,
        PH_RINSE = 2'b01,
        PH_SPIN  = 2'b10
    } phase_e;

    typedef enum logic [1:0] {
        RUN_IDLE   = 2'b00,
        RUN_ACTIVE = 2'b01,
        RUN_PAUSED = 2'b10
    } run_state_e;

    function automatic model_e next_model(model_e m);
        return (m == MODEL_S) ? MODEL_WRS : model_e'(m + 3'd1);
    endfunction

    function automatic phase_e first_phase(model_e m);
        case (m)
            MODEL_WRS, MODEL_W, MODEL_WR: return PH_WASH;
            MODEL_R, MODEL_RS:            return PH_RINSE;
            default:                      return PH_SPIN;
        endcase
    endfunction

    // Phases always run in wash->rinse->spin order, so only the successor check is model-specific.
    function automatic logic has_next_phase(model_e m, phase_e p);
        case (p)
            PH_WASH:  return (m == MODEL_WRS) || (m == MODEL_WR);
            PH_RINSE: return (m == MODEL_WRS) || (m == MODEL_RS);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic phase_e next_phase(phase_e p);
        return (p == PH_WASH) ? PH_RINSE : PH_SPIN;
    endfunction

    function automatic ticks_t phase_len(phase_e p, ticks_t tw, ticks_t tr, ticks_t ts);
        case (p)
            PH_WASH:  return tw;
            PH_RINSE: return tr;
            default:  return ts;
        endcase
    endfunction

    function automatic ticks_t model_total(model_e m, ticks_t tw, ticks_t tr, ticks_t ts);
        ticks_t sum;
        sum = '0;
        if (m inside {MODEL_WRS, MODEL_W, MODEL_WR})           sum = sum + tw;
        if (m inside {MODEL_WRS, MODEL_WR, MODEL_R, MODEL_RS}) sum = sum + tr;
        if (m inside {MODEL_WRS, MODEL_RS, MODEL_S})           sum = sum + ts;
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wash_controller_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : wash_controller_if
// Brief  : Key/tick inputs and status outputs of the washer controller.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
interface wash_controller_if;

    logic       tick_1hz;
    logic       power_on;
    logic       start_pulse;
    logic       model_pulse;
    logic       clothes_pulse;
    logic       order_pulse;
    logic [2:0] current_model;
    logic [1:0] current_program;
    logic [1:0] run_state;
    logic [6:0] rest_time;
    logic [6:0] remain_time;
    logic       finish;

    modport master (
        output tick_1hz, power_on, start_pulse, model_pulse, clothes_pulse, order_pulse,
        input  current_model, current_program, run_state, rest_time, remain_time, finish
    );

    modport slave (
        input  tick_1hz, power_on, start_pulse, model_pulse, clothes_pulse, order_pulse,
        output current_model, current_program, run_state, rest_time, remain_time, finish
    );

endinterface
`default_nettype wire

// File: rtl/wash_phase_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : wash_phase_timer
// Brief  : Loadable down-counter for the active phase; flags its final tick.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module wash_phase_timer
    import wash_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear_i,
    input  logic   load_i,
    input  ticks_t load_val_i,
    input  logic   dec_i,
    output logic   last_o
);

    ticks_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - ticks_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Registered-only decode so the controller can use it without a comb loop.
    assign last_o = (count_q == ticks_t'(1));

endmodule
`default_nettype wire

// File: rtl/wash_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : wash_controller
// Brief  : Washing-machine program FSM with model selection and delay start.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module wash_controller
    import wash_pkg::*;
#(
    parameter int unsigned T_WASH    = DEF_T_WASH,
    parameter int unsigned T_RINSE   = DEF_T_RINSE,
    parameter int unsigned T_SPIN    = DEF_T_SPIN,
    parameter int unsigned ORDER_MAX = DEF_ORDER_MAX
) (
    input  logic                clk,
    input  logic                rst_n,
    wash_controller_if.slave    bus
);

    localparam ticks_t C_TW        = ticks_t'(T_WASH);
    localparam ticks_t C_TR        = ticks_t'(T_RINSE);
    localparam ticks_t C_TS        = ticks_t'(T_SPIN);
    localparam ticks_t C_ORDER_MAX = ticks_t'(ORDER_MAX);
    localparam ticks_t C_TOTAL_RST = ticks_t'(T_WASH + T_RINSE + T_SPIN);

    model_e     model_q,   model_d;
    phase_e     program_q, program_d;
    run_state_e run_q,     run_d;
    ticks_t     rest_q,    rest_d;
    ticks_t     remain_q,  remain_d;
    logic       finish_q,  finish_d;

    logic       w_tmr_clear;
    logic       w_tmr_load;
    ticks_t     w_tmr_load_val;
    logic       w_tmr_dec;
    logic       w_tmr_last;

    wash_phase_timer u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (w_tmr_clear),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_load_val),
        .dec_i      (w_tmr_dec),
        .last_o     (w_tmr_last)
    );

    // Each branch is taken only if its key is acceptable in the current state,
    // so a rejected higher-priority key lets the next one (or the tick) through.
    always_comb begin
        model_d        = model_q;
        program_d      = program_q;
        run_d          = run_q;
        rest_d         = rest_q;
        remain_d       = remain_q;
        finish_d       = finish_q;
        w_tmr_clear    = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = '0;
        w_tmr_dec      = 1'b0;

        if (!bus.power_on) begin
            model_d     = MODEL_WRS;
            program_d   = PH_WASH;
            run_d       = RUN_IDLE;
            rest_d      = '0;
            remain_d    = C_TOTAL_RST;
            finish_d    = 1'b0;
            w_tmr_clear = 1'b1;
        end else if (bus.start_pulse) begin
            case (run_q)
                RUN_IDLE: begin
                    run_d          = RUN_ACTIVE;
                    finish_d       = 1'b0;
                    program_d      = first_phase(model_q);
                    remain_d       = model_total(model_q, C_TW, C_TR, C_TS);
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = phase_len(first_phase(model_q), C_TW, C_TR, C_TS);
                end
                RUN_ACTIVE: run_d = RUN_PAUSED;
                default:    run_d = RUN_ACTIVE;
            endcase
        end else if (bus.clothes_pulse && (run_q == RUN_ACTIVE) && (program_q == PH_WASH)) begin
            run_d = RUN_PAUSED;
        end else if (bus.model_pulse && (run_q == RUN_IDLE)) begin
            model_d   = next_model(model_q);
            finish_d  = 1'b0;
            program_d = first_phase(next_model(model_q));
            remain_d  = model_total(next_model(model_q), C_TW, C_TR, C_TS);
        end else if (bus.order_pulse && (run_q == RUN_IDLE)) begin
            rest_d = (rest_q >= C_ORDER_MAX) ? '0 : rest_q + ticks_t'(1);
        end else if (bus.tick_1hz && (run_q == RUN_ACTIVE)) begin
            if (rest_q != '0) begin
                rest_d = rest_q - ticks_t'(1);
            end else begin
                remain_d  = remain_q - ticks_t'(1);
                w_tmr_dec = 1'b1;
                if (w_tmr_last) begin
                    if (has_next_phase(model_q, program_q)) begin
                        program_d      = next_phase(program_q);
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = phase_len(next_phase(program_q), C_TW, C_TR, C_TS);
                    end else begin
                        remain_d  = '0;
                        finish_d  = 1'b1;
                        run_d     = RUN_IDLE;
                        model_d   = MODEL_WRS;
                        program_d = PH_WASH;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q   <= MODEL_WRS;
            program_q <= PH_WASH;
            run_q     <= RUN_IDLE;
            rest_q    <= '0;
            remain_q  <= C_TOTAL_RST;
            finish_q  <= 1'b0;
        end else begin
            model_q   <= model_d;
            program_q <= program_d;
            run_q     <= run_d;
            rest_q    <= rest_d;
            remain_q  <= remain_d;
            finish_q  <= finish_d;
        end
    end

    assign bus.current_model   = model_q;
    assign bus.current_program = program_q;
    assign bus.run_state       = run_q;
    assign bus.rest_time       = rest_q;
    assign bus.remain_time     = remain_q;
    assign bus.finish          = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_wash_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_wash_controller
// Brief  : Directed scenarios plus random keys against a phase-queue model.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_wash_controller;

    localparam int TW = 9;
    localparam int TR = 6;
    localparam int TS = 3;
    localparam int OMAX = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    wash_controller_if bus ();

    wash_controller #(
        .T_WASH    (TW),
        .T_RINSE   (TR),
        .T_SPIN    (TS),
        .ORDER_MAX (OMAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: the running program is a queue of phases with ticks left each.
    int r_model, r_run, r_rest, r_finish;
    int r_ph[$];
    int r_left[$];

    function automatic int plen(int p);
        return (p == 0) ? TW : ((p == 1) ? TR : TS);
    endfunction

    function automatic void r_load();
        int seq[$];
        case (r_model)
            0:       seq = '{0, 1, 2};
            1:       seq = '{0};
            2:       seq = '{0, 1};
            3:       seq = '{1};
            4:       seq = '{1, 2};
            default: seq = '{2};
        endcase
        r_ph = seq;
        r_left.delete();
        foreach (seq[i]) r_left.push_back(plen(seq[i]));
    endfunction

    function automatic void r_reset();
        r_model = 0; r_run = 0; r_rest = 0; r_finish = 0;
        r_load();
    endfunction

    function automatic int r_prog();
        return (r_ph.size() != 0) ? r_ph[0] : 0;
    endfunction

    function automatic int r_remain();
        int s = 0;
        foreach (r_left[i]) s += r_left[i];
        return s;
    endfunction

    function automatic void r_step(bit pw, bit st, bit mo, bit cl, bit od, bit tk);
        if (!pw) begin
            r_reset();
        end else if (st) begin
            if (r_run == 0) begin
                r_run = 1; r_finish = 0; r_load();
            end else begin
                r_run = (r_run == 1) ? 2 : 1;
            end
        end else if (cl && r_run == 1 && r_prog() == 0) begin
            r_run = 2;
        end else if (mo && r_run == 0) begin
            r_model = (r_model + 1) % 6; r_finish = 0; r_load();
        end else if (od && r_run == 0) begin
            r_rest = (r_rest == OMAX) ? 0 : r_rest + 1;
        end else if (tk && r_run == 1) begin
            if (r_rest > 0) begin
                r_rest--;
            end else begin
                r_left[0] = r_left[0] - 1;
                if (r_left[0] == 0) begin
                    void'(r_ph.pop_front());
                    void'(r_left.pop_front());
                    if (r_ph.size() == 0) begin
                        r_finish = 1; r_run = 0; r_model = 0;
                    end
                end
            end
        end
    endfunction

    task automatic step(input bit pw, input bit st, input bit mo, input bit cl, input bit od, input bit tk);
        @(negedge clk);
        bus.power_on = pw; bus.start_pulse = st; bus.model_pulse = mo;
        bus.clothes_pulse = cl; bus.order_pulse = od; bus.tick_1hz = tk;
        r_step(pw, st, mo, cl, od, tk);
        @(posedge clk);
        #1;
        bus.start_pulse = 1'b0; bus.model_pulse = 1'b0; bus.clothes_pulse = 1'b0;
        bus.order_pulse = 1'b0; bus.tick_1hz = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 1);
    endtask

    task automatic power_clean();
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #10;
        n_checks++;
        if (bus.current_model !== 3'd0 || bus.current_program !== 2'd0 || bus.run_state !== 2'd0 ||
            bus.rest_time !== 7'd0 || bus.remain_time !== 7'd18 || bus.finish !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: model=%0d prog=%0d run=%0d rest=%0d remain=%0d finish=%0d, expected 0 0 0 0 18 0",
                     bus.current_model, bus.current_program, bus.run_state, bus.rest_time, bus.remain_time, bus.finish);
        end
        @(negedge clk);
        rst_n = 1'b1;
        r_reset();
    endtask

    task automatic test_wrs_program();
        power_clean();
        step(1, 1, 0, 0, 0, 0);
        for (int t = 1; t <= 18; t++) begin
            step(1, 0, 0, 0, 0, 1);
            n_checks++;
            if (bus.current_program !== 2'(r_prog()) || bus.remain_time !== 7'(r_remain()) ||
                bus.finish !== 1'(r_finish)) begin
                n_fail++;
                $display("FAIL wrs_tick%0d: prog=%0d remain=%0d finish=%0d, expected %0d %0d %0d", t,
                         bus.current_program, bus.remain_time, bus.finish, r_prog(), r_remain(), r_finish);
            end
            if (t == 9 || t == 15) begin
                n_checks++;
                if (bus.current_program !== ((t == 9) ? 2'd1 : 2'd2)) begin
                    n_fail++;
                    $display("FAIL wrs_phase_change tick%0d: prog=%0d", t, bus.current_program);
                end
            end
        end
        n_checks++;
        if (bus.finish !== 1'b1 || bus.run_state !== 2'd0 || bus.remain_time !== 7'd0 || bus.current_model !== 3'd0) begin
            n_fail++;
            $display("FAIL wrs_done: finish=%0d run=%0d remain=%0d model=%0d, expected 1 0 0 0",
                     bus.finish, bus.run_state, bus.remain_time, bus.current_model);
        end
        step(1, 1, 0, 0, 0, 0);
        n_checks++;
        if (bus.finish !== 1'b0 || bus.run_state !== 2'd1 || bus.remain_time !== 7'd18 || bus.current_program !== 2'd0) begin
            n_fail++;
            $display("FAIL wrs_restart: finish=%0d run=%0d remain=%0d prog=%0d, expected 0 1 18 0",
                     bus.finish, bus.run_state, bus.remain_time, bus.current_program);
        end
    endtask

    task automatic test_model_cycle();
        power_clean();
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
        n_checks++;
        if (bus.current_model !== 3'd3 || bus.current_program !== 2'd1 || bus.remain_time !== 7'd6) begin
            n_fail++;
            $display("FAIL model3: model=%0d prog=%0d remain=%0d, expected 3 1 6",
                     bus.current_model, bus.current_program, bus.remain_time);
        end
        step(1, 1, 0, 0, 0, 0);
        ticks(6);
        n_checks++;
        if (bus.finish !== 1'b1 || bus.run_state !== 2'd0) begin
            n_fail++;
            $display("FAIL model3_done: finish=%0d run=%0d, expected 1 0", bus.finish, bus.run_state);
        end
        step(1, 0, 1, 0, 0, 0);
        n_checks++;
        if (bus.finish !== 1'b0 || bus.current_model !== 3'd1 || bus.remain_time !== 7'd9) begin
            n_fail++;
            $display("FAIL model_clears_finish: finish=%0d model=%0d remain=%0d, expected 0 1 9",
                     bus.finish, bus.current_model, bus.remain_time);
        end
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0);
        n_checks++;
        if (bus.current_model !== 3'd0 || bus.remain_time !== 7'd18) begin
            n_fail++;
            $display("FAIL model_wrap: model=%0d remain=%0d, expected 0 18", bus.current_model, bus.remain_time);
        end
    endtask

    task automatic test_delay_start();
        int exp_rest[3] = '{1, 0, 0};
        int exp_rem[3]  = '{18, 18, 17};
        power_clean();
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        n_checks++;
        if (bus.rest_time !== 7'd2 || bus.run_state !== 2'd1) begin
            n_fail++;
            $display("FAIL delay_armed: rest=%0d run=%0d, expected 2 1", bus.rest_time, bus.run_state);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 1);
            n_checks++;
            if (bus.rest_time !== 7'(exp_rest[i]) || bus.remain_time !== 7'(exp_rem[i])) begin
                n_fail++;
                $display("FAIL delay_tick%0d: rest=%0d remain=%0d, expected %0d %0d",
                         i, bus.rest_time, bus.remain_time, exp_rest[i], exp_rem[i]);
            end
        end
        power_clean();
        for (int i = 0; i < OMAX + 1; i++) step(1, 0, 0, 0, 1, 0);
        n_checks++;
        if (bus.rest_time !== 7'd0) begin
            n_fail++;
            $display("FAIL order_wrap: rest=%0d, expected 0", bus.rest_time);
        end
    endtask

    task automatic test_clothes_pause();
        power_clean();
        step(1, 1, 0, 0, 0, 0);
        ticks(4);
        step(1, 0, 0, 1, 0, 0);
        n_checks++;
        if (bus.run_state !== 2'd2) begin
            n_fail++;
            $display("FAIL clothes_pause: run=%0d, expected 2", bus.run_state);
        end
        ticks(5);
        n_checks++;
        if (bus.remain_time !== 7'd14 || bus.run_state !== 2'd2) begin
            n_fail++;
            $display("FAIL paused_ticks: remain=%0d run=%0d, expected 14 2", bus.remain_time, bus.run_state);
        end
        step(1, 1, 0, 0, 0, 0);
        ticks(5);
        n_checks++;
        if (bus.run_state !== 2'd1 || bus.current_program !== 2'd1 || bus.remain_time !== 7'd9) begin
            n_fail++;
            $display("FAIL resume_to_rinse: run=%0d prog=%0d remain=%0d, expected 1 1 9",
                     bus.run_state, bus.current_program, bus.remain_time);
        end
        step(1, 0, 0, 1, 0, 1);
        n_checks++;
        if (bus.run_state !== 2'd1 || bus.remain_time !== 7'd8) begin
            n_fail++;
            $display("FAIL clothes_in_rinse: run=%0d remain=%0d, expected 1 8", bus.run_state, bus.remain_time);
        end
    endtask

    task automatic test_start_tick_same();
        power_clean();
        step(1, 1, 0, 0, 0, 0);
        ticks(3);
        step(1, 1, 0, 0, 0, 1);
        n_checks++;
        if (bus.run_state !== 2'd2 || bus.remain_time !== 7'd15) begin
            n_fail++;
            $display("FAIL start_with_tick: run=%0d remain=%0d, expected 2 15", bus.run_state, bus.remain_time);
        end
    endtask

    task automatic test_power_off();
        power_clean();
        step(1, 1, 0, 0, 0, 0);
        ticks(11);
        for (int i = 0; i < 4; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1);
            n_checks++;
            if (bus.current_model !== 3'd0 || bus.current_program !== 2'd0 || bus.run_state !== 2'd0 ||
                bus.rest_time !== 7'd0 || bus.remain_time !== 7'd18 || bus.finish !== 1'b0) begin
                n_fail++;
                $display("FAIL power_off%0d: model=%0d prog=%0d run=%0d rest=%0d remain=%0d finish=%0d, expected 0 0 0 0 18 0", i,
                         bus.current_model, bus.current_program, bus.run_state, bus.rest_time, bus.remain_time, bus.finish);
            end
        end
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        power_clean();
        step(1, 1, 0, 0, 0, 0);
        ticks(16);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (bus.current_model !== 3'd0 || bus.current_program !== 2'd0 || bus.run_state !== 2'd0 ||
                bus.rest_time !== 7'd0 || bus.remain_time !== 7'd18 || bus.finish !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset%0d: model=%0d prog=%0d run=%0d rest=%0d remain=%0d finish=%0d, expected 0 0 0 0 18 0", i,
                         bus.current_model, bus.current_program, bus.run_state, bus.rest_time, bus.remain_time, bus.finish);
            end
            bus.tick_1hz = 1'b1;
            @(posedge clk);
            #1 bus.tick_1hz = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        r_reset();
    endtask

    task automatic test_random();
        bit pw, st, mo, cl, od, tk;
        for (int c = 0; c < 800; c++) begin
            pw = ($urandom_range(0, 99) != 0);
            st = ($urandom_range(0, 11) == 0);
            mo = ($urandom_range(0, 5) == 0);
            cl = ($urandom_range(0, 7) == 0);
            od = ($urandom_range(0, 7) == 0);
            tk = ($urandom_range(0, 1) == 0);
            step(pw, st, mo, cl, od, tk);
            n_checks++;
            if (bus.current_model !== 3'(r_model) || bus.current_program !== 2'(r_prog()) ||
                bus.run_state !== 2'(r_run) || bus.rest_time !== 7'(r_rest) ||
                bus.remain_time !== 7'(r_remain()) || bus.finish !== 1'(r_finish)) begin
                n_fail++;
                $display("FAIL random cyc%0d: model=%0d prog=%0d run=%0d rest=%0d remain=%0d finish=%0d, expected %0d %0d %0d %0d %0d %0d",
                         c, bus.current_model, bus.current_program, bus.run_state, bus.rest_time, bus.remain_time,
                         bus.finish, r_model, r_prog(), r_run, r_rest, r_remain(), r_finish);
            end
        end
    endtask

    initial begin
        bus.power_on = 1'b1; bus.start_pulse = 1'b0; bus.model_pulse = 1'b0;
        bus.clothes_pulse = 1'b0; bus.order_pulse = 1'b0; bus.tick_1hz = 1'b0;
        r_reset();
        test_reset();
        test_wrs_program();
        test_model_cycle();
        test_delay_start();
        test_clothes_pause();
        test_start_tick_same();
        test_power_off();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wash_controller.md
WASH_CONTROLLER -- requirements
Module: wash_controller

Interface
REQ-001 Parameter T_WASH, default 9, wash phase length in tick_1hz periods.
REQ-002 Parameter T_RINSE, default 6, rinse phase length in ticks.
REQ-003 Parameter T_SPIN, default 3, spin phase length in ticks; T_WASH+T_RINSE+T_SPIN SHALL be at most 127.
REQ-004 Parameter ORDER_MAX, default 24, delay-start ceiling in ticks.
REQ-005 clk  in  1  system clock; one clock; all state on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 tick_1hz  in  1  one-cycle pulse, once per second.
REQ-008 power_on  in  1  level; 0 = machine off.
REQ-009 start_pulse, model_pulse, clothes_pulse, order_pulse  in  1 each  one-cycle debounced key pulses.
REQ-010 current_model  out  3  000 wash-rinse-spin, 001 wash, 010 wash-rinse, 011 rinse, 100 rinse-spin, 101 spin.
REQ-011 current_program  out  2  active phase: 00 wash, 01 rinse, 10 spin.
REQ-012 run_state  out  2  00 idle, 01 running, 10 paused; 11 never driven.
REQ-013 rest_time  out  7  remaining delay-start ticks.
REQ-014 remain_time  out  7  remaining program ticks.
REQ-015 finish  out  1  program complete, level.

Function
REQ-016 Event priority per cycle: power_on=0 > start_pulse > clothes_pulse > model_pulse > order_pulse > tick_1hz.
REQ-017 power_on=0 SHALL force all outputs and internal state to reset values on the next edge and hold them.
REQ-018 Idle: model_pulse SHALL advance current_model 000->001->...->101->000 and clear finish.
REQ-019 Idle: current_program SHALL equal the model's first phase (00 for 000/001/010, 01 for 011/100, 10 for 101); remain_time SHALL equal the sum of the model's phase lengths.
REQ-020 Idle: order_pulse SHALL increment rest_time, wrapping ORDER_MAX->0.
REQ-021 Idle + start_pulse -> run_state 01, finish cleared.
REQ-022 Running + start_pulse -> 10; paused + start_pulse -> 01; model_pulse and order_pulse ignored unless idle.
REQ-023 Running + clothes_pulse -> 10 only while current_program=00; ignored otherwise.
REQ-024 A tick counts only when run_state=01 and no key pulse was accepted that cycle.
REQ-025 Counted tick with rest_time>0 SHALL decrement rest_time only.
REQ-026 Counted tick with rest_time=0 SHALL decrement remain_time and the phase counter.
REQ-027 When the phase counter expires, the next phase of the model SHALL load, with current_program updated on the same edge.
REQ-028 When the last phase expires: remain_time=0, finish=1, run_state=00, current_model=000, current_program=00, all on the same edge.
REQ-029 finish SHALL hold until model_pulse, start_pulse or power_on=0; a start_pulse that clears finish SHALL start a new 000 program.
REQ-030 Outputs are registered; response latency is one clk after the qualifying input.

Reset
REQ-031 While rst_n=0: current_model=000, current_program=00, run_state=00, rest_time=0, remain_time=T_WASH+T_RINSE+T_SPIN, finish=0, phase counter=0.
REQ-032 Reset asserted mid-program SHALL abort immediately with no completion pulse.

Structure
REQ-033 Package wash_pkg SHALL hold the model, phase and run_state encodings and the default durations.
REQ-034 Sub-module wash_phase_timer SHALL hold the loadable phase down-counter and signal expiry; wash_controller SHALL hold the FSM and model sequencing.

Verification
REQ-035 Reset, model 000, start, 18 ticks: program 00->01 after tick 9, 01->10 after tick 15, finish=1 and run_state=00 after tick 18.
REQ-036 Idle, three model_pulse: model=011, program=01, remain_time=6; start, 6 ticks -> finish=1.
REQ-037 Two order_pulse, start: rest_time 2->1->0 over 2 ticks with remain_time=18 throughout, then normal countdown.
REQ-038 Running in wash after 4 ticks, clothes_pulse: run_state=10, 5 ticks leave remain_time=14; start_pulse resumes; clothes_pulse in rinse ignored.
REQ-039 start_pulse and tick_1hz in the same cycle while running: paused, remain_time unchanged.
REQ-040 power_on=0 mid-rinse: all outputs at reset values next cycle and held; rst_n low mid-spin gives the same result asynchronously.
